// File: rtl/adder_exhaustive_tester.sv
// On-chip exhaustive checker for a combinational W-bit adder: sweeps every {cin, b, a},
// samples the adder's sum after a programmable settle time and reports verdict and first failure.
module adder_exhaustive_tester #(
    parameter int WIDTH       = 4,
    parameter int SETTLE      = 1,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_cin,
    input  logic [WIDTH:0]       dut_sum,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     first_err_vec,
    output logic [WIDTH:0]       first_err_sum
);

    // state   | meaning
    // IDLE    | waiting for start; results of the last run held
    // DRIVE   | vector on the adder inputs, settle counter running
    // CHECK   | adder output compared against reference at exit edge
    // FINISH  | one-cycle done pulse, verdict valid

    localparam int VW = 2*WIDTH + 1;
    localparam int EW = 2*WIDTH + 2;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_CHECK  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [VW-1:0]   r_vec;
    logic [CW-1:0]   r_cnt;
    logic [EW-1:0]   r_err;
    logic [VW-1:0]   r_first_vec;
    logic [WIDTH:0]  r_first_sum;
    logic            r_pass;

    logic [VW-1:0]   w_vec_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [EW-1:0]   w_err_nxt;
    logic [VW-1:0]   w_first_vec_nxt;
    logic [WIDTH:0]  w_first_sum_nxt;
    logic            w_pass_nxt;

    logic [WIDTH:0]  w_ref;
    logic            w_mismatch;
    logic            w_last;
    logic            w_stop;

    // Reference carries the full WIDTH+1 result so a dropped carry-out is caught.
    assign w_ref = {1'b0, r_vec[WIDTH-1:0]}
                 + {1'b0, r_vec[2*WIDTH-1:WIDTH]}
                 + {{WIDTH{1'b0}}, r_vec[2*WIDTH]};

    assign w_mismatch = (w_ref != dut_sum);
    assign w_last     = (r_vec == {VW{1'b1}});
    assign w_stop     = (STOP_ON_ERR != 0) && w_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_vec_nxt       = r_vec;
        w_cnt_nxt       = r_cnt;
        w_err_nxt       = r_err;
        w_first_vec_nxt = r_first_vec;
        w_first_sum_nxt = r_first_sum;
        w_pass_nxt      = r_pass;
        busy            = 1'b0;
        done            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_vec_nxt       = '0;
                    w_cnt_nxt       = CNT_LOAD;
                    w_err_nxt       = '0;
                    w_first_vec_nxt = '0;
                    w_first_sum_nxt = '0;
                    w_pass_nxt      = 1'b0;
                    w_state_nxt     = S_DRIVE;
                end
            end

            S_DRIVE: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            S_CHECK: begin
                busy = 1'b1;
                if (w_mismatch) begin
                    w_err_nxt = r_err + EW'(1);
                    if (r_err == '0) begin
                        w_first_vec_nxt = r_vec;
                        w_first_sum_nxt = dut_sum;
                    end
                end
                if (w_last || w_stop) begin
                    // Verdict registered on entry so it is already valid during done.
                    w_pass_nxt  = (r_err == '0) && !w_mismatch;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_vec_nxt   = r_vec + VW'(1);
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = S_DRIVE;
                end
            end

            S_FINISH: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec       <= '0;
            r_cnt       <= '0;
            r_err       <= '0;
            r_first_vec <= '0;
            r_first_sum <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_vec       <= w_vec_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_first_vec <= w_first_vec_nxt;
            r_first_sum <= w_first_sum_nxt;
            r_pass      <= w_pass_nxt;
        end
    end

    assign dut_a         = r_vec[WIDTH-1:0];
    assign dut_b         = r_vec[2*WIDTH-1:WIDTH];
    assign dut_cin       = r_vec[2*WIDTH];
    assign pass          = r_pass;
    assign err_count     = r_err;
    assign first_err_vec = r_first_vec;
    assign first_err_sum = r_first_sum;

endmodule

// File: tb/tb_adder_exhaustive_tester.sv
// Bench for adder_exhaustive_tester: three instances (default, SETTLE=3, STOP_ON_ERR=1) driven
// against a behavioural adder with selectable and randomized faults.
module tb_adder_exhaustive_tester;

    localparam int NV = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       start_r;
    logic [2:0][3:0]  a_w, b_w;
    logic [2:0]       cin_w;
    logic [2:0][4:0]  sum_w;
    logic [2:0]       busy_w, done_w, pass_w;
    logic [2:0][9:0]  errc_w;
    logic [2:0][8:0]  fvec_w;
    logic [2:0][4:0]  fsum_w;

    int         mode;
    bit         corrupt [NV];
    logic [4:0] cmask [NV];

    int n_cmp = 0;
    int n_mis = 0;

    adder_exhaustive_tester #(.WIDTH(4), .SETTLE(1), .STOP_ON_ERR(0)) u_dut (
        .clk(clk), .rst(rst), .start(start_r[0]),
        .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_cin(cin_w[0]), .dut_sum(sum_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(errc_w[0]),
        .first_err_vec(fvec_w[0]), .first_err_sum(fsum_w[0]));

    adder_exhaustive_tester #(.WIDTH(4), .SETTLE(3), .STOP_ON_ERR(0)) u_dut_s3 (
        .clk(clk), .rst(rst), .start(start_r[1]),
        .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_cin(cin_w[1]), .dut_sum(sum_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(errc_w[1]),
        .first_err_vec(fvec_w[1]), .first_err_sum(fsum_w[1]));

    adder_exhaustive_tester #(.WIDTH(4), .SETTLE(1), .STOP_ON_ERR(1)) u_dut_stop (
        .clk(clk), .rst(rst), .start(start_r[2]),
        .dut_a(a_w[2]), .dut_b(b_w[2]), .dut_cin(cin_w[2]), .dut_sum(sum_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(errc_w[2]),
        .first_err_vec(fvec_w[2]), .first_err_sum(fsum_w[2]));

    // Adder under test: 0 ideal, 1 sum bit0 stuck at 0, 2 ignores cin, 3 random corrupted vectors.
    function automatic logic [4:0] model_sum(input int m, input logic [8:0] v);
        int a, b, c, s;
        a = int'(v[3:0]);
        b = int'(v[7:4]);
        c = int'(v[8]);
        s = a + b + c;
        case (m)
            1:       s = s & ~1;
            2:       s = a + b;
            3:       s = s ^ (corrupt[int'(v)] ? int'(cmask[int'(v)]) : 0);
            default: ;
        endcase
        return 5'(s);
    endfunction

    always_comb begin
        sum_w[0] = model_sum(mode, {cin_w[0], b_w[0], a_w[0]});
        sum_w[1] = model_sum(mode, {cin_w[1], b_w[1], a_w[1]});
        sum_w[2] = model_sum(mode, {cin_w[2], b_w[2], a_w[2]});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Expected results from a plain sweep of all vectors against true addition.
    task automatic expect_stats(input int m, output int cnt, output int first, output int fsum);
        int ideal;
        logic [4:0] got;
        cnt = 0; first = 0; fsum = 0;
        for (int v = 0; v < NV; v++) begin
            ideal = (v & 15) + ((v >> 4) & 15) + ((v >> 8) & 1);
            got = model_sum(m, 9'(v));
            if (int'(got) != ideal) begin
                if (cnt == 0) begin
                    first = v;
                    fsum  = int'(got);
                end
                cnt++;
            end
        end
    endtask

    task automatic randomize_faults();
        int n, idx;
        for (int v = 0; v < NV; v++) begin
            corrupt[v] = 1'b0;
            cmask[v]   = 5'd0;
        end
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
            idx = $urandom_range(0, NV - 1);
            corrupt[idx] = 1'b1;
            cmask[idx]   = 5'($urandom_range(1, 31));
        end
    endtask

    // Pulse start on instance d and follow the run; edges are counted from E0 (start capture).
    task automatic run(input int d, input bit poke,
                       output int done_edge, output int busy_cyc, output int overlap,
                       output int bad_steps, output int err_at_start, output int idle_ok);
        int sp, last_change;
        logic [8:0] prev, cur;
        sp = (d == 1) ? 3 : 1;
        done_edge = -1; busy_cyc = 0; overlap = 0; bad_steps = 0; idle_ok = 1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start_r[d] = 1'b1;
        @(posedge clk);
        #1;
        start_r[d] = 1'b0;
        err_at_start = int'(errc_w[d]);
        if (busy_w[d]) busy_cyc++;
        prev = {cin_w[d], b_w[d], a_w[d]};
        last_change = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 50) start_r[d] = 1'b1;
            if (poke && k == 51) start_r[d] = 1'b0;
            if (busy_w[d]) busy_cyc++;
            if (busy_w[d] && done_w[d]) overlap++;
            cur = {cin_w[d], b_w[d], a_w[d]};
            if (cur != prev) begin
                if (cur != prev + 9'd1 || (k - last_change) != sp + 1) bad_steps++;
                last_change = k;
                prev = cur;
            end
            if (done_w[d]) begin
                done_edge = k;
                break;
            end
        end
        if (poke && done_edge > 0) begin
            start_r[d] = 1'b1;
            @(posedge clk);
            #1;
            start_r[d] = 1'b0;
            @(posedge clk);
            #1;
            idle_ok = (!busy_w[d] && !done_w[d]) ? 1 : 0;
        end
    endtask

    int de, bc, ov, bad, eas, iok;
    int e_cnt, e_first, e_fsum;
    int k_done;

    initial begin
        start_r = '0;
        mode    = 0;
        for (int v = 0; v < NV; v++) begin
            corrupt[v] = 1'b0;
            cmask[v]   = 5'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_pass", pass_w[0], 0);
        check("rst_err", errc_w[0], 0);
        check("rst_vec", {cin_w[0], b_w[0], a_w[0]}, 0);
        rst = 1'b0;

        // Ideal adder, defaults
        mode = 0;
        run(0, 0, de, bc, ov, bad, eas, iok);
        check("ideal_done_edge", de, 1024);
        check("ideal_busy_cycles", bc, 1024);
        check("ideal_busy_done_overlap", ov, 0);
        check("ideal_step", bad, 0);
        check("ideal_pass", pass_w[0], 1);
        check("ideal_err", errc_w[0], 0);
        check("ideal_fvec", fvec_w[0], 0);
        check("ideal_fsum", fsum_w[0], 0);
        check("ideal_last_vec", {cin_w[0], b_w[0], a_w[0]}, 9'h1FF);

        // Stuck bit 0, with start pokes mid-run and in the FINISH cycle
        mode = 1;
        run(0, 1, de, bc, ov, bad, eas, iok);
        check("stuck_done_edge", de, 1024);
        check("stuck_busy_cycles", bc, 1024);
        check("stuck_err", errc_w[0], 256);
        check("stuck_pass", pass_w[0], 0);
        check("stuck_fvec", fvec_w[0], 9'h001);
        check("stuck_fsum", fsum_w[0], 5'h00);
        check("stuck_no_restart", iok, 1);
        repeat (5) @(posedge clk);
        #1;
        check("stuck_hold_err", errc_w[0], 256);
        check("stuck_hold_fvec", fvec_w[0], 9'h001);

        // Carry-in ignored
        mode = 2;
        run(0, 0, de, bc, ov, bad, eas, iok);
        check("nocin_err_cleared_at_start", eas, 0);
        check("nocin_done_edge", de, 1024);
        check("nocin_err", errc_w[0], 256);
        check("nocin_fvec", fvec_w[0], 9'h100);
        check("nocin_fsum", fsum_w[0], 5'h00);

        // Carry-in ignored, stop on first error
        run(2, 0, de, bc, ov, bad, eas, iok);
        check("stop_done_edge", de, 514);
        check("stop_err", errc_w[2], 1);
        check("stop_pass", pass_w[2], 0);
        check("stop_fvec", fvec_w[2], 9'h100);
        check("stop_last_vec", {cin_w[2], b_w[2], a_w[2]}, 9'h100);

        // Start held high from the FINISH cycle: ignored there, new run at the IDLE edge
        start_r[2] = 1'b1;
        @(posedge clk);
        #1;
        check("hold_start_finish_ignored", busy_w[2], 0);
        @(posedge clk);
        #1;
        start_r[2] = 1'b0;
        check("hold_start_restart_busy", busy_w[2], 1);
        k_done = -1;
        for (int k = 1; k <= 700; k++) begin
            @(posedge clk);
            #1;
            if (done_w[2]) begin
                k_done = k;
                break;
            end
        end
        check("restart_done_edge", k_done, 514);
        check("restart_err", errc_w[2], 1);

        // Randomized corrupted vectors
        mode = 3;
        for (int t = 0; t < 3; t++) begin
            randomize_faults();
            expect_stats(3, e_cnt, e_first, e_fsum);
            run(0, 0, de, bc, ov, bad, eas, iok);
            check("rnd_done_edge", de, 1024);
            check("rnd_err", errc_w[0], e_cnt);
            check("rnd_fvec", fvec_w[0], e_first);
            check("rnd_fsum", fsum_w[0], e_fsum);
            check("rnd_pass", pass_w[0], (e_cnt == 0) ? 1 : 0);
            run(2, 0, de, bc, ov, bad, eas, iok);
            check("rnd_stop_edge", de, (e_first + 1) * 2);
            check("rnd_stop_err", errc_w[2], 1);
            check("rnd_stop_fvec", fvec_w[2], e_first);
        end

        // SETTLE=3
        mode = 0;
        run(1, 0, de, bc, ov, bad, eas, iok);
        check("s3_done_edge", de, 2048);
        check("s3_busy_cycles", bc, 2048);
        check("s3_step", bad, 0);
        check("s3_pass", pass_w[1], 1);
        mode = 3;
        randomize_faults();
        expect_stats(3, e_cnt, e_first, e_fsum);
        run(1, 0, de, bc, ov, bad, eas, iok);
        check("s3_rnd_err", errc_w[1], e_cnt);
        check("s3_rnd_fvec", fvec_w[1], e_first);

        // Reset mid-run at E100
        mode = 1;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", busy_w[0], 0);
        check("midrst_done", done_w[0], 0);
        check("midrst_pass", pass_w[0], 0);
        check("midrst_err", errc_w[0], 0);
        check("midrst_fvec", fvec_w[0], 0);
        check("midrst_fsum", fsum_w[0], 0);
        check("midrst_vec", {cin_w[0], b_w[0], a_w[0]}, 0);
        k_done = 0;
        for (int k = 0; k < 1100; k++) begin
            @(posedge clk);
            #1;
            if (done_w[0] || busy_w[0]) k_done++;
        end
        check("midrst_no_done", k_done, 0);
        mode = 0;
        run(0, 0, de, bc, ov, bad, eas, iok);
        check("after_rst_done_edge", de, 1024);
        check("after_rst_pass", pass_w[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/adder_exhaustive_tester.md
# adder_exhaustive_tester

Synthesizable self-checking driver for the team's W-bit Brent-Kung adder, the counterpart of the adder's input/output ports. On `start` it sweeps every `{cin, b, a}` combination into a combinational adder under test and samples its `sum` after a programmable settle time. It compares each sample against an internal reference, then reports a pass/fail verdict, the error count, and the first failing vector. It sits beside the adder in FPGA bring-up builds, replacing the simulation-only exhaustive loop with on-chip checking.

## Interface
- `WIDTH`, 4: operand width of the adder under test; vector count N = 2^(2·WIDTH+1).
- `SETTLE`, 1: cycles (≥1) the vector is held before sampling.
- `STOP_ON_ERR`, 0: 1 = end the run at the first mismatch.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `dut_a`  out  WIDTH  operand A to adder.
- `dut_b`  out  WIDTH  operand B to adder.
- `dut_cin`  out  1  carry-in to adder.
- `dut_sum`  in  WIDTH+1  adder result (combinational from `dut_*`).
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at run end.
- `pass`  out  1  verdict; valid from `done` until next `start`.
- `err_count`  out  2·WIDTH+2  mismatches in current/last run.
- `first_err_vec`  out  2·WIDTH+1  `{cin,b,a}` of first mismatch.
- `first_err_sum`  out  WIDTH+1  `dut_sum` seen at first mismatch.

## Operation
- Reset (`rst`=1 at an edge): state IDLE; all outputs 0, including `dut_*`, `busy`, `done`, `pass`, `err_count`, `first_err_*`. Applies mid-run too: the run is aborted and no `done` is produced.
- Vector index `v` (2·WIDTH+1 bits). `{dut_cin, dut_b, dut_a}` = `v`, registered.
- Reference = `dut_a + dut_b + dut_cin`, computed at WIDTH+1 bits, with no truncation of the carry. A mismatch is any bit difference from `dut_sum`.
- States:
  - IDLE: `busy`=0. When `start`=1: `v`←0, settle counter←SETTLE−1, `err_count`←0, `first_err_*`←0, `pass`←0, go to DRIVE.
  - DRIVE: `busy`=1. Decrement the settle counter; at 0, go to CHECK.
  - CHECK: `busy`=1. Compare. On mismatch: increment `err_count`; if it was 0, capture `first_err_vec`=`v` and `first_err_sum`=`dut_sum`. Then:
    - if `v`=N−1, or (STOP_ON_ERR and mismatch): go to FINISH;
    - else `v`←`v`+1, reload the settle counter, go to DRIVE.
  - FINISH: `busy`=0, `done`=1, `pass`=(`err_count`==0). Go to IDLE next edge.
- `start` is ignored in DRIVE, CHECK and FINISH. A `start` held high in IDLE begins a new run immediately.
- `err_count` width holds N exactly; no saturation needed.
- `pass`, `err_count` and `first_err_*` hold their values in IDLE until the next `start` or reset.
- `dut_*` keep the last vector after the run ends.

## Timing
- The edge capturing `start` is E0. Vector 0 appears on `dut_*` after E0.
- Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE, 1 in CHECK. The compare happens at the CHECK-exit edge.
- Full run: FINISH is entered at edge E(N·(SETTLE+1)), so `done` is high in the following cycle. With defaults, `done` is high after E1024.
- STOP_ON_ERR early exit at vector k: `done` is high after edge E((k+1)·(SETTLE+1)).
- `busy` rises after E0 and falls in the same cycle `done` rises. `done` is never high with `busy`.
- Earliest restart: `start` is sampled at the first IDLE edge, one cycle after `done`.

## Test plan
- Ideal adder, defaults: `start` pulse -> `done` after E1024, `pass`=1, `err_count`=0, `first_err_*`=0, `busy` high exactly 1024 cycles.
- `dut_sum[0]` stuck at 0 -> `err_count`=256, `pass`=0, `first_err_vec`=9'h001, `first_err_sum`=5'h00.
- Adder ignoring cin -> `err_count`=256, `first_err_vec`=9'h100, `first_err_sum`=5'h00. With STOP_ON_ERR=1: `done` after E514, `err_count`=1.
- SETTLE=3, ideal adder -> `done` after E2048. Each vector is stable for 4 cycles before it changes.
- `rst` asserted at E100 mid-run -> all outputs 0 the next cycle, no `done` pulse. A fresh `start` then completes normally with `pass`=1.
- `start` re-pulsed while `busy`, and again in the FINISH cycle -> ignored. Run timing and results are unchanged, and no second run starts.
